// File: rtl/rs_dec_frame_sequencer.sv
// ---------------------------------------------------------------------------
// rs_dec_frame_sequencer
// Per-codeword controller for the C1 Reed-Solomon decoder front end.
// Frames N_SYMB input symbols into the syndrome calculator, launches the
// Euclid stage only when a syndrome is nonzero, guards both stages with
// timeouts, and reports per-codeword status plus frame / error counters.
//
// Ports
//   i_clk, i_res                 clock, synchronous active-high reset
//   i_frame_start, i_data,
//   i_data_valid                 input symbol stream from the deframer
//   o_synd_frame, o_synd_data,
//   o_synd_dsync                 registered symbol stream to syndrome calc
//   i_synd_ready, i_s0..i_s3     syndrome done pulse and syndromes
//   o_euclid_start               one-cycle Euclid launch pulse
//   i_euclid_ready               Euclid done pulse
//   o_busy                       high whenever not IDLE
//   o_done, o_clean, o_timeout   end-of-codeword pulse and held status
//   o_overrun                    frame start seen while busy (pulse)
//   o_frame_cnt, o_err_cnt       wrapping codeword / error counters
// ---------------------------------------------------------------------------
module rs_dec_frame_sequencer #(
    parameter int N_SYMB     = 32,
    parameter int SYND_TMO   = 8,
    parameter int EUCLID_TMO = 64,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_frame_start,
    input  logic [7:0]       i_data,
    input  logic             i_data_valid,
    output logic             o_synd_frame,
    output logic [7:0]       o_synd_data,
    output logic             o_synd_dsync,
    input  logic             i_synd_ready,
    input  logic [7:0]       i_s0,
    input  logic [7:0]       i_s1,
    input  logic [7:0]       i_s2,
    input  logic [7:0]       i_s3,
    output logic             o_euclid_start,
    input  logic             i_euclid_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_clean,
    output logic             o_timeout,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int SYM_W   = $clog2(N_SYMB + 1);
    localparam int TMO_MAX = (SYND_TMO > EUCLID_TMO) ? SYND_TMO : EUCLID_TMO;
    localparam int TMR_W   = $clog2(TMO_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_SYND, EUCLID, WAIT_EUC, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [SYM_W-1:0] sym_cnt;
    logic [TMR_W-1:0] tmr;

    logic fs_valid, synd_zero;
    logic accept, first, tmr_clr, fin, fin_clean, fin_to;

    assign fs_valid  = i_frame_start & i_data_valid;
    assign synd_zero = ~|{i_s0, i_s1, i_s2, i_s3};

    assign o_busy         = (state != IDLE);
    assign o_euclid_start = (state == EUCLID);
    assign o_done         = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        first     = 1'b0;
        tmr_clr   = 1'b0;
        fin       = 1'b0;
        fin_clean = 1'b0;
        fin_to    = 1'b0;
        case (state)
            IDLE: begin
                if (fs_valid) begin
                    accept    = 1'b1;
                    first     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // a frame start here is an overrun but still counts as data
                if (i_data_valid) begin
                    accept = 1'b1;
                    if (sym_cnt == SYM_W'(N_SYMB - 1)) begin
                        state_nxt = WAIT_SYND;
                        tmr_clr   = 1'b1;
                    end
                end
            end
            WAIT_SYND: begin
                // ready is checked before expiry so a last-cycle ready wins
                if (i_synd_ready) begin
                    if (synd_zero) begin
                        fin       = 1'b1;
                        fin_clean = 1'b1;
                    end else begin
                        state_nxt = EUCLID;
                    end
                end else if (tmr == TMR_W'(SYND_TMO - 1)) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            EUCLID: begin
                state_nxt = WAIT_EUC;
                tmr_clr   = 1'b1;
            end
            WAIT_EUC: begin
                if (i_euclid_ready) begin
                    fin = 1'b1;
                end else if (tmr == TMR_W'(EUCLID_TMO - 1)) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (fin) state_nxt = DONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state        <= IDLE;
            sym_cnt      <= '0;
            tmr          <= '0;
            o_synd_frame <= 1'b0;
            o_synd_data  <= '0;
            o_synd_dsync <= 1'b0;
            o_overrun    <= 1'b0;
            o_clean      <= 1'b0;
            o_timeout    <= 1'b0;
            o_frame_cnt  <= '0;
            o_err_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            o_synd_dsync <= accept;
            o_synd_frame <= first;
            o_overrun    <= (state != IDLE) & fs_valid;
            if (accept) begin
                o_synd_data <= i_data;
                sym_cnt     <= first ? SYM_W'(1) : sym_cnt + 1'b1;
            end
            if (tmr_clr)
                tmr <= '0;
            else if (state == WAIT_SYND || state == WAIT_EUC)
                tmr <= tmr + 1'b1;
            // status and counters update on entry to DONE so they are
            // already valid while o_done is high
            if (fin) begin
                o_clean     <= fin_clean;
                o_timeout   <= fin_to;
                o_frame_cnt <= o_frame_cnt + 1'b1;
                if (!fin_clean) o_err_cnt <= o_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs_dec_frame_sequencer.sv
// Bench for rs_dec_frame_sequencer: directed codeword scenarios plus random
// frames, with a cycle-level behavioural model compared on every cycle.
module tb_rs_dec_frame_sequencer;
    localparam int N  = 32;
    localparam int ST = 8;
    localparam int ET = 64;
    localparam int CW = 4;   // narrow counters so the wrap is reachable

    logic clk = 1'b0, res = 1'b1;
    logic fs = 1'b0, v = 1'b0, sr = 1'b0, er = 1'b0;
    logic [7:0] d = '0, s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic synd_frame, synd_dsync, euclid_start, busy, done, clean, tmo, overrun;
    logic [7:0] synd_data;
    logic [CW-1:0] frame_cnt, err_cnt;

    rs_dec_frame_sequencer #(.N_SYMB(N), .SYND_TMO(ST), .EUCLID_TMO(ET), .CNT_W(CW)) dut (
        .i_clk(clk), .i_res(res), .i_frame_start(fs), .i_data(d), .i_data_valid(v),
        .o_synd_frame(synd_frame), .o_synd_data(synd_data), .o_synd_dsync(synd_dsync),
        .i_synd_ready(sr), .i_s0(s0), .i_s1(s1), .i_s2(s2), .i_s3(s3),
        .o_euclid_start(euclid_start), .i_euclid_ready(er), .o_busy(busy), .o_done(done),
        .o_clean(clean), .o_timeout(tmo), .o_overrun(overrun),
        .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 loading, 2 waiting syndromes, 3 launching Euclid,
    //        4 waiting Euclid, 5 reporting
    int m_ph = 0, m_got = 0, m_wt = 0, m_fc = 0, m_ec = 0;
    logic e_frame = 0, e_dsync = 0, e_over = 0, e_clean = 0, e_to = 0;
    logic [7:0] e_data = '0;

    task automatic m_finish(input logic c, input logic t);
        m_ph    = 5;
        e_clean = c;
        e_to    = t;
        m_fc    = (m_fc + 1) % (1 << CW);
        if (!c) m_ec = (m_ec + 1) % (1 << CW);
    endtask

    task automatic model_step();
        logic fsv;
        e_frame = 0; e_dsync = 0; e_over = 0;
        if (res) begin
            m_ph = 0; m_got = 0; m_wt = 0; m_fc = 0; m_ec = 0;
            e_data = '0; e_clean = 0; e_to = 0;
            return;
        end
        fsv = fs && v;
        if (m_ph != 0 && fsv) e_over = 1;
        case (m_ph)
            0: if (fsv) begin
                   e_data = d; e_frame = 1; e_dsync = 1; m_got = 1; m_ph = 1;
               end
            1: if (v) begin
                   e_data = d; e_dsync = 1; m_got++;
                   if (m_got == N) begin m_ph = 2; m_wt = 0; end
               end
            2: begin
                   m_wt++;   // cycles spent waiting, this one included
                   if (sr) begin
                       if ({s0, s1, s2, s3} == 32'd0) m_finish(1, 0);
                       else m_ph = 3;
                   end else if (m_wt == ST) m_finish(0, 1);
               end
            3: begin m_ph = 4; m_wt = 0; end
            4: begin
                   m_wt++;
                   if (er) m_finish(0, 0);
                   else if (m_wt == ET) m_finish(0, 1);
               end
            default: m_ph = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor + per-cycle compare ----------------
    int dsync_n = 0, frame_n = 0, start_n = 0, done_n = 0, over_n = 0;
    int last_dsync_cyc = 0, start_cyc = 0, done_cyc = 0;
    logic done_clean = 0, done_to = 0;
    logic [7:0] rxq[$];
    logic [7:0] symq[$];

    initial forever begin
        @(negedge clk);
        chk("busy",     busy,         m_ph != 0);
        chk("start",    euclid_start, m_ph == 3);
        chk("done",     done,         m_ph == 5);
        chk("frame",    synd_frame,   e_frame);
        chk("dsync",    synd_dsync,   e_dsync);
        chk("data",     synd_data,    e_data);
        chk("overrun",  overrun,      e_over);
        chk("clean",    clean,        e_clean);
        chk("timeout",  tmo,          e_to);
        chk("frm_cnt",  frame_cnt,    m_fc);
        chk("err_cnt",  err_cnt,      m_ec);
        if (synd_dsync === 1'b1) begin
            dsync_n++; last_dsync_cyc = cyc; rxq.push_back(synd_data);
        end
        if (synd_frame === 1'b1)   frame_n++;
        if (overrun === 1'b1)      over_n++;
        if (euclid_start === 1'b1) begin start_n++; start_cyc = cyc; end
        if (done === 1'b1) begin
            done_n++; done_cyc = cyc; done_clean = clean; done_to = tmo;
        end
    end

    task automatic clr_mon();
        dsync_n = 0; frame_n = 0; start_n = 0; done_n = 0; over_n = 0;
        rxq.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_idle();
        fs = 0; v = 0; sr = 0; er = 0;
        d = 8'($urandom); s0 = 8'($urandom); s1 = 8'($urandom);
        s2 = 8'($urandom); s3 = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin set_idle(); tick(); end
    endtask

    task automatic send_frame(input int nsym, input int maxgap, input int ovr_idx, input bit noise);
        symq.delete();
        for (int i = 0; i < nsym; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                set_idle();
                if (noise) begin sr = ($urandom_range(0, 7) == 0); er = ($urandom_range(0, 7) == 0); end
                tick();
            end
            set_idle();
            if (noise) begin sr = ($urandom_range(0, 7) == 0); er = ($urandom_range(0, 7) == 0); end
            v = 1; d = 8'($urandom); symq.push_back(d);
            fs = (i == 0) || (i == ovr_idx);
            tick();
        end
    endtask

    // ready arrives on the sd-th syndrome-wait cycle (0 = never)
    task automatic synd_resp(input int sd, input logic [31:0] sv);
        if (sd > 0) begin
            idle(sd - 1);
            set_idle(); sr = 1; {s0, s1, s2, s3} = sv; tick();
        end
    endtask

    // ready arrives ed cycles after the launch pulse (0 = never);
    // an extra frame start is injected ovr_at cycles after launch
    task automatic euc_resp(input int ed, input int ovr_at);
        int last;
        for (int k = 0; k < 16 && euclid_start !== 1'b1; k++) idle(1);
        if (euclid_start !== 1'b1) return;
        idle(1);
        last = (ed > 0) ? ed : ovr_at;
        for (int j = 1; j <= last; j++) begin
            set_idle();
            if (j == ed) er = 1;
            if (j == ovr_at) begin fs = 1; v = 1; end
            tick();
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && done_n == 0; k++) idle(1);
        chk("done_seen", done_n, 1);
    endtask

    task automatic run_frame(input int maxgap, input int ovr_idx, input int sd, input logic [31:0] sv,
                             input int ed, input int ovr_at, input bit noise);
        clr_mon();
        send_frame(N, maxgap, ovr_idx, noise);
        synd_resp(sd, sv);
        if (sd >= 1 && sd <= ST && sv != 32'd0) euc_resp(ed, ovr_at);
        wait_done();
    endtask

    task automatic chk_order();
        int bad = 0;
        if (rxq.size() != symq.size()) bad = 1000;
        else for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== symq[i]) bad++;
        chk("data_order", bad, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        set_idle(); res = 1;
        idle(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dsync", synd_dsync, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);
        res = 0;
        idle(2);

        // clean codeword, syndromes ready 3 cycles after the last symbol
        run_frame(0, -1, 3, 32'd0, 0, 0, 0);
        chk("clean_dsync_n", dsync_n, 32);
        chk("clean_frame_n", frame_n, 1);
        chk("clean_start_n", start_n, 0);
        chk("clean_flag", done_clean, 1);
        chk("clean_to", done_to, 0);
        chk("clean_lat", done_cyc - last_dsync_cyc, 3);
        chk("clean_fcnt", frame_cnt, 1);
        chk("clean_ecnt", err_cnt, 0);
        chk_order();

        // s1 = 5A -> Euclid launched, ready 20 cycles after launch
        run_frame(0, -1, 2, 32'h005A_0000, 20, 0, 0);
        chk("err_start_n", start_n, 1);
        chk("err_clean", done_clean, 0);
        chk("err_to", done_to, 0);
        chk("err_lat", done_cyc - start_cyc, 21);
        chk("err_fcnt", frame_cnt, 2);
        chk("err_ecnt", err_cnt, 1);

        // input stalls of up to 5 cycles
        run_frame(5, -1, 1, 32'd0, 0, 0, 0);
        chk("stall_dsync_n", dsync_n, 32);
        chk("stall_frame_n", frame_n, 1);
        chk_order();

        // syndrome timeout, then ready on the last allowed cycle
        run_frame(0, -1, 0, 32'd0, 0, 0, 0);
        chk("stmo_to", done_to, 1);
        chk("stmo_lat", done_cyc - last_dsync_cyc, 8);
        run_frame(0, -1, 8, 32'd0, 0, 0, 0);
        chk("s8_to", done_to, 0);
        chk("s8_clean", done_clean, 1);
        chk("s8_lat", done_cyc - last_dsync_cyc, 8);

        // Euclid timeout, then ready on cycle 64
        run_frame(0, -1, 1, 32'h0000_0001, 0, 0, 0);
        chk("etmo_to", done_to, 1);
        chk("etmo_lat", done_cyc - start_cyc, 65);
        run_frame(0, -1, 1, 32'h8000_0000, 64, 0, 0);
        chk("e64_to", done_to, 0);
        chk("e64_lat", done_cyc - start_cyc, 65);

        // overrun while loading and while waiting for Euclid
        run_frame(1, 10, 2, 32'd0, 0, 0, 0);
        chk("ovl_over_n", over_n, 1);
        chk("ovl_frame_n", frame_n, 1);
        chk("ovl_dsync_n", dsync_n, 32);
        chk_order();
        run_frame(0, -1, 2, 32'h0000_3300, 20, 5, 0);
        chk("ove_over_n", over_n, 1);
        chk("ove_start_n", start_n, 1);
        chk("ove_dsync_n", dsync_n, 32);

        // reset in the middle of a load
        clr_mon();
        send_frame(10, 0, -1, 0);
        set_idle(); res = 1; tick(); res = 0;
        chk("mrst_busy", busy, 0);
        chk("mrst_fcnt", frame_cnt, 0);
        chk("mrst_ecnt", err_cnt, 0);
        clr_mon();
        idle(5);
        chk("mrst_done_n", done_n, 0);
        chk("mrst_dsync_n", dsync_n, 0);

        // counter wrap (4-bit counters here), back-to-back frames
        for (int i = 0; i < 15; i++) run_frame(0, -1, 1, 32'd0, 0, 0, 0);
        chk("wrap_15", frame_cnt, 15);
        run_frame(0, -1, 1, 32'd0, 0, 0, 0);
        chk("wrap_0", frame_cnt, 0);
        chk("wrap_ecnt", err_cnt, 0);

        // random frames: gaps, noise readies, timeouts, overruns
        for (int i = 0; i < 25; i++) begin
            logic [31:0] sv;
            sv = ($urandom_range(0, 1) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
            run_frame($urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : -1,
                      $urandom_range(0, 10), sv, $urandom_range(0, 70),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0, 1);
            chk("rnd_dsync_n", dsync_n, 32);
            chk_order();
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
